// File: rtl/slice_detector.sv
// slice_detector: two-stage saber slice, note miss and obstacle hit detector; define SLICE_3D_EN to add a tip-depth overlap test
module slice_detector #(
  parameter int NUM_SABERS     = 2,
  parameter int MOVE_THRESHOLD = 32,
  parameter int HIT_RADIUS     = 100,
  parameter int SLICE_Z_MAX    = 600,
  parameter int COOLDOWN       = 1
) (
  input  logic                     clk_in,
  input  logic                     rst_in_n,
  input  logic [17:0]              curr_time,
  input  logic                     blk_valid,
  input  logic [11:0]              blk_x,
  input  logic [11:0]              blk_y,
  input  logic [13:0]              blk_z,
  input  logic                     blk_visible,
  input  logic                     blk_obstacle,
  input  logic                     blk_color,
  input  logic [2:0]               blk_dir,
  input  logic [7:0]               blk_id,
  input  logic [NUM_SABERS*24-1:0] tip_prev_xy,
  input  logic [NUM_SABERS*24-1:0] tip_curr_xy,
  input  logic [NUM_SABERS*14-1:0] tip_z,
  input  logic [11:0]              head_x,
  input  logic [11:0]              head_y,
  input  logic [13:0]              head_z,
  output logic                     slice_valid,
  output logic [1:0]               slice_saber,
  output logic [7:0]               slice_id,
  output logic [11:0]              slice_x,
  output logic [11:0]              slice_y,
  output logic [13:0]              slice_z,
  output logic                     slice_color,
  output logic [2:0]               slice_dir,
  output logic                     miss_pulse,
  output logic                     hit_pulse,
  output logic [7:0]               combo
);
  localparam logic [2:0] DIR_UP    = 3'd0;
  localparam logic [2:0] DIR_RIGHT = 3'd1;
  localparam logic [2:0] DIR_DOWN  = 3'd2;
  localparam logic [2:0] DIR_LEFT  = 3'd3;
  localparam logic [2:0] DIR_ANY   = 3'd4;
  localparam logic [12:0] MOVE_T = 13'(MOVE_THRESHOLD);
  localparam logic signed [13:0] RAD14 = 14'(HIT_RADIUS);
  localparam logic [13:0] Z_MAX = 14'(SLICE_Z_MAX);
  localparam logic [17:0] COOL = 18'(COOLDOWN);
`ifdef SLICE_3D_EN
  localparam logic signed [14:0] RAD15 = 15'(HIT_RADIUS);
`endif

  logic        s1_valid, s1_visible, s1_obstacle, s1_color;
  logic [11:0] s1_x, s1_y, s1_head_x, s1_head_y;
  logic [13:0] s1_z, s1_head_z;
  logic [2:0]  s1_dir;
  logic [7:0]  s1_id;
  logic [17:0] s1_time;
  logic [7:0]  last_id, miss_id;
  logic [17:0] last_time;
  logic signed [13:0] bx, by, hdx, hdy, hadx, hady;
  logic [NUM_SABERS-1:0] cand;
  logic [1:0]  win;
  logic        note_ok, accept, miss, hit;

  // Stage 1: capture the block, head and time alongside the per-saber motion
  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      s1_valid    <= 1'b0;
      s1_visible  <= 1'b0;
      s1_obstacle <= 1'b0;
      s1_color    <= 1'b0;
      s1_x        <= '0;
      s1_y        <= '0;
      s1_z        <= '0;
      s1_dir      <= '0;
      s1_id       <= '0;
      s1_time     <= '0;
      s1_head_x   <= '0;
      s1_head_y   <= '0;
      s1_head_z   <= '0;
    end else begin
      s1_valid    <= blk_valid;
      s1_visible  <= blk_visible;
      s1_obstacle <= blk_obstacle;
      s1_color    <= blk_color;
      s1_x        <= blk_x;
      s1_y        <= blk_y;
      s1_z        <= blk_z;
      s1_dir      <= blk_dir;
      s1_id       <= blk_id;
      s1_time     <= curr_time;
      s1_head_x   <= head_x;
      s1_head_y   <= head_y;
      s1_head_z   <= head_z;
    end
  end

  assign bx = $signed({2'b00, s1_x});
  assign by = $signed({2'b00, s1_y});
  assign note_ok = s1_valid && s1_visible && !s1_obstacle && s1_z <= Z_MAX;

  for (genvar s = 0; s < NUM_SABERS; s++) begin : g_saber
    logic [11:0] prev_x, prev_y, curr_x, curr_y, s1_px, s1_py;
    logic signed [12:0] dx, dy, s1_dx, s1_dy;
    logic [12:0] s1_adx, s1_ady;
    logic signed [13:0] px, py;
    logic [2:0] dir;
    logic ovl_xy, ovl;
    assign prev_x = tip_prev_xy[s*24+12 +: 12];
    assign prev_y = tip_prev_xy[s*24 +: 12];
    assign curr_x = tip_curr_xy[s*24+12 +: 12];
    assign curr_y = tip_curr_xy[s*24 +: 12];
    assign dx = $signed({1'b0, curr_x}) - $signed({1'b0, prev_x});
    assign dy = $signed({1'b0, curr_y}) - $signed({1'b0, prev_y});
    // Stage 1: per-saber displacement, its magnitude and the previous tip position
    always_ff @(posedge clk_in or negedge rst_in_n) begin
      if (!rst_in_n) begin
        s1_dx  <= '0;
        s1_dy  <= '0;
        s1_adx <= '0;
        s1_ady <= '0;
        s1_px  <= '0;
        s1_py  <= '0;
      end else begin
        s1_dx  <= dx;
        s1_dy  <= dy;
        s1_adx <= dx < 13'sd0 ? -dx : dx;
        s1_ady <= dy < 13'sd0 ? -dy : dy;
        s1_px  <= prev_x;
        s1_py  <= prev_y;
      end
    end
    assign dir = (s1_adx >= MOVE_T && s1_adx > s1_ady) ? (s1_dx < 13'sd0 ? DIR_LEFT : DIR_RIGHT) :
                 (s1_ady >= MOVE_T && s1_ady > s1_adx) ? (s1_dy < 13'sd0 ? DIR_UP : DIR_DOWN) : DIR_ANY;
    assign px = $signed({2'b00, s1_px});
    assign py = $signed({2'b00, s1_py});
    assign ovl_xy = (px - RAD14 <= bx) && (bx <= px + RAD14) && (py - RAD14 <= by) && (by <= py + RAD14);
`ifdef SLICE_3D_EN
    logic [13:0] s1_tz;
    logic signed [14:0] dz;
    // Stage 1: tip depth for the 3D overlap test
    always_ff @(posedge clk_in or negedge rst_in_n) begin
      if (!rst_in_n) s1_tz <= '0;
      else s1_tz <= tip_z[s*14 +: 14];
    end
    assign dz = $signed({1'b0, s1_tz}) - $signed({1'b0, s1_z});
    assign ovl = ovl_xy && (dz < 15'sd0 ? -dz : dz) <= RAD15;
`else
    assign ovl = ovl_xy;
`endif
    assign cand[s] = note_ok && dir != DIR_ANY && (dir == s1_dir || s1_dir == DIR_ANY) && ovl;
  end

`ifndef SLICE_3D_EN
  logic unused_tip_z;
  assign unused_tip_z = ^tip_z;
`endif

  // Lowest-index candidate saber wins
  always_comb begin
    win = '0;
    for (int i = NUM_SABERS - 1; i >= 0; i--) win = cand[i] ? 2'(i) : win;
  end

  assign accept = |cand && s1_id != last_id && (s1_time - last_time) >= COOL;
  assign miss = s1_valid && s1_visible && !s1_obstacle && s1_z == 14'd0 && s1_id != miss_id;
  assign hdx = bx - $signed({2'b00, s1_head_x});
  assign hdy = by - $signed({2'b00, s1_head_y});
  assign hadx = hdx < 14'sd0 ? -hdx : hdx;
  assign hady = hdy < 14'sd0 ? -hdy : hdy;
  assign hit = s1_valid && s1_visible && s1_obstacle && hadx <= RAD14 && hady <= RAD14 && s1_z <= s1_head_z;

  // Stage 2: pulses, held slice record, duplicate/cooldown state and combo (miss clear wins over slice)
  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      slice_valid <= 1'b0;
      slice_saber <= '0;
      slice_id    <= '0;
      slice_x     <= '0;
      slice_y     <= '0;
      slice_z     <= '0;
      slice_color <= 1'b0;
      slice_dir   <= '0;
      miss_pulse  <= 1'b0;
      hit_pulse   <= 1'b0;
      combo       <= '0;
      last_id     <= 8'hFF;
      last_time   <= '0;
      miss_id     <= '0;
    end else begin
      slice_valid <= accept;
      miss_pulse  <= miss;
      hit_pulse   <= hit;
      combo       <= miss ? 8'd0 : accept ? combo + {7'd0, combo != 8'hFF} : combo;
      if (accept) begin
        slice_saber <= win;
        slice_id    <= s1_id;
        slice_x     <= s1_x;
        slice_y     <= s1_y;
        slice_z     <= s1_z;
        slice_color <= s1_color;
        slice_dir   <= s1_dir;
        last_id     <= s1_id;
        last_time   <= s1_time;
      end
      if (miss) miss_id <= s1_id;
    end
  end
endmodule

// File: tb/tb_slice_detector.sv
// tb_slice_detector: directed scenarios plus a randomized run against a behavioural model of slice_detector
module tb_slice_detector;
  localparam int NS = 2;
  logic clk_in = 1'b0, rst_in_n = 1'b1;
  logic [17:0] curr_time = 18'd100;
  logic blk_valid = 0, blk_visible = 0, blk_obstacle = 0, blk_color = 0;
  logic [11:0] blk_x = 0, blk_y = 0, head_x = 0, head_y = 0;
  logic [13:0] blk_z = 0, head_z = 0;
  logic [2:0] blk_dir = 0;
  logic [7:0] blk_id = 0;
  logic [NS*24-1:0] tip_prev_xy = '0, tip_curr_xy = '0;
  logic [NS*14-1:0] tip_z = '0;
  logic slice_valid, slice_color, miss_pulse, hit_pulse;
  logic [1:0] slice_saber;
  logic [7:0] slice_id, combo;
  logic [11:0] slice_x, slice_y;
  logic [13:0] slice_z;
  logic [2:0] slice_dir;
  int checks = 0, failures = 0, exp_combo = 0;

  typedef struct packed {
    logic sv; logic [1:0] saber; logic [7:0] id; logic [11:0] x, y; logic [13:0] z;
    logic color; logic [2:0] dir; logic miss, hit; logic [7:0] combo;
  } exp_t;

  slice_detector #(.NUM_SABERS(NS)) dut (
    .clk_in(clk_in), .rst_in_n(rst_in_n), .curr_time(curr_time), .blk_valid(blk_valid),
    .blk_x(blk_x), .blk_y(blk_y), .blk_z(blk_z), .blk_visible(blk_visible),
    .blk_obstacle(blk_obstacle), .blk_color(blk_color), .blk_dir(blk_dir), .blk_id(blk_id),
    .tip_prev_xy(tip_prev_xy), .tip_curr_xy(tip_curr_xy), .tip_z(tip_z),
    .head_x(head_x), .head_y(head_y), .head_z(head_z), .slice_valid(slice_valid),
    .slice_saber(slice_saber), .slice_id(slice_id), .slice_x(slice_x), .slice_y(slice_y),
    .slice_z(slice_z), .slice_color(slice_color), .slice_dir(slice_dir),
    .miss_pulse(miss_pulse), .hit_pulse(hit_pulse), .combo(combo)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
    curr_time = curr_time + 18'd1;
  endtask

  task automatic set_tip(input int s, input int px, input int py, input int cx, input int cy);
    tip_prev_xy[s*24 +: 24] = {12'(px), 12'(py)};
    tip_curr_xy[s*24 +: 24] = {12'(cx), 12'(cy)};
  endtask

  task automatic still_tips();
    for (int s = 0; s < NS; s++) set_tip(s, 3000, 3000, 3000, 3000);
  endtask

  task automatic set_blk(input int x, input int y, input int z, input logic obs, input int dir, input int id);
    blk_valid = 1; blk_visible = 1; blk_obstacle = obs;
    blk_x = 12'(x); blk_y = 12'(y); blk_z = 14'(z); blk_dir = 3'(dir); blk_id = 8'(id); blk_color = blk_id[0];
    for (int s = 0; s < NS; s++) tip_z[s*14 +: 14] = 14'(z);
  endtask

  task automatic idle();
    blk_valid = 0; blk_visible = 0;
  endtask

  task automatic test_reset();
    idle(); still_tips();
    #2 rst_in_n = 0;
    #1;
    checks++;
    if ({slice_valid, miss_pulse, hit_pulse, slice_saber, slice_id, slice_x, slice_y, slice_z, slice_color, slice_dir} !== '0) begin
      failures++; $display("FAIL reset_outputs got=%0h exp=0", {slice_valid, miss_pulse, hit_pulse, slice_saber, slice_id, slice_x, slice_y, slice_z, slice_color, slice_dir});
    end
    checks++;
    if (combo !== 8'd0) begin failures++; $display("FAIL reset_combo got=%0d exp=0", combo); end
    @(posedge clk_in); @(negedge clk_in) rst_in_n = 1;
    set_tip(0, 500, 500, 560, 510); set_blk(520, 480, 300, 0, 1, 255);
    tick(); idle(); tick();
    checks++;
    if (slice_valid !== 1'b0) begin failures++; $display("FAIL reset_last_id_ff got=%0b exp=0", slice_valid); end
  endtask

  task automatic test_slice();
    still_tips(); set_tip(0, 500, 500, 560, 510); set_blk(520, 480, 300, 0, 1, 5);
    tick();
    checks++;
    if (slice_valid !== 1'b0) begin failures++; $display("FAIL slice_early got=%0b exp=0", slice_valid); end
    tick(); exp_combo++;
    checks++;
    if ({slice_valid, slice_saber, slice_id, slice_x, slice_y, slice_z, slice_color, slice_dir} !== {1'b1, 2'd0, 8'd5, 12'd520, 12'd480, 14'd300, 1'b1, 3'd1}) begin
      failures++; $display("FAIL slice_basic got=%0h exp=%0h", {slice_valid, slice_saber, slice_id, slice_x, slice_y, slice_z, slice_color, slice_dir}, {1'b1, 2'd0, 8'd5, 12'd520, 12'd480, 14'd300, 1'b1, 3'd1});
    end
    checks++;
    if (combo !== 8'(exp_combo)) begin failures++; $display("FAIL slice_combo got=%0d exp=%0d", combo, exp_combo); end
    idle(); tick();
    checks++;
    if ({slice_valid, slice_id} !== {1'b0, 8'd5}) begin failures++; $display("FAIL same_id got=%0h exp=%0h", {slice_valid, slice_id}, {1'b0, 8'd5}); end
    checks++;
    if (combo !== 8'(exp_combo)) begin failures++; $display("FAIL same_id_combo got=%0d exp=%0d", combo, exp_combo); end
  endtask

  task automatic test_dual_sabers();
    set_tip(0, 1000, 1000, 1005, 1050); set_tip(1, 1000, 1000, 1005, 1050); set_blk(1010, 1020, 100, 0, 4, 9);
    tick(); idle(); tick(); exp_combo++;
    checks++;
    if ({slice_valid, slice_saber, slice_id, combo} !== {1'b1, 2'd0, 8'd9, 8'(exp_combo)}) begin
      failures++; $display("FAIL dual_saber got=%0h exp=%0h", {slice_valid, slice_saber, slice_id, combo}, {1'b1, 2'd0, 8'd9, 8'(exp_combo)});
    end
    tick();
    checks++;
    if (slice_valid !== 1'b0) begin failures++; $display("FAIL dual_single_pulse got=%0b exp=0", slice_valid); end
  endtask

  task automatic test_threshold();
    still_tips(); set_tip(0, 2000, 2000, 2031, 2000); set_blk(2000, 2000, 200, 0, 4, 20);
    tick(); idle(); tick();
    checks++;
    if (slice_valid !== 1'b0) begin failures++; $display("FAIL move_31 got=%0b exp=0", slice_valid); end
    set_tip(0, 2000, 2000, 2032, 2000); set_blk(2000, 2000, 200, 0, 4, 21);
    tick(); idle(); tick(); exp_combo++;
    checks++;
    if ({slice_valid, slice_saber, slice_id, slice_dir, combo} !== {1'b1, 2'd0, 8'd21, 3'd4, 8'(exp_combo)}) begin
      failures++; $display("FAIL move_32 got=%0h exp=%0h", {slice_valid, slice_saber, slice_id, slice_dir, combo}, {1'b1, 2'd0, 8'd21, 3'd4, 8'(exp_combo)});
    end
  endtask

  task automatic test_miss();
    still_tips(); set_blk(500, 500, 0, 0, 4, 12);
    tick(); tick(); exp_combo = 0;
    checks++;
    if ({miss_pulse, slice_valid, combo} !== {1'b1, 1'b0, 8'd0}) begin
      failures++; $display("FAIL miss got=%0h exp=%0h", {miss_pulse, slice_valid, combo}, {1'b1, 1'b0, 8'd0});
    end
    idle(); tick();
    checks++;
    if (miss_pulse !== 1'b0) begin failures++; $display("FAIL miss_same_id got=%0b exp=0", miss_pulse); end
    set_tip(0, 800, 800, 850, 800); set_blk(800, 800, 0, 0, 1, 13);
    tick(); idle(); tick();
    checks++;
    if ({slice_valid, miss_pulse, combo} !== {1'b1, 1'b1, 8'd0}) begin
      failures++; $display("FAIL slice_and_miss got=%0h exp=%0h", {slice_valid, miss_pulse, combo}, {1'b1, 1'b1, 8'd0});
    end
  endtask

  task automatic test_hit();
    still_tips(); set_blk(100, 100, 50, 1, 4, 40); head_x = 150; head_y = 120; head_z = 60;
    tick(); idle();
    checks++;
    if (hit_pulse !== 1'b0) begin failures++; $display("FAIL hit_early got=%0b exp=0", hit_pulse); end
    tick();
    checks++;
    if ({hit_pulse, slice_valid, miss_pulse} !== 3'b100) begin failures++; $display("FAIL hit got=%0b exp=100", {hit_pulse, slice_valid, miss_pulse}); end
    tick();
    checks++;
    if (hit_pulse !== 1'b0) begin failures++; $display("FAIL hit_one_cycle got=%0b exp=0", hit_pulse); end
    set_blk(100, 100, 50, 1, 4, 41); head_z = 49;
    tick(); idle(); tick();
    checks++;
    if (hit_pulse !== 1'b0) begin failures++; $display("FAIL hit_behind_head got=%0b exp=0", hit_pulse); end
  endtask

  task automatic test_window_edge();
    still_tips(); set_tip(0, 50, 50, 150, 60); set_blk(0, 0, 300, 0, 1, 30);
    tick(); idle(); tick(); exp_combo++;
    checks++;
    if ({slice_valid, slice_saber, slice_id} !== {1'b1, 2'd0, 8'd30}) begin
      failures++; $display("FAIL window_low_edge got=%0h exp=%0h", {slice_valid, slice_saber, slice_id}, {1'b1, 2'd0, 8'd30});
    end
    still_tips(); set_tip(1, 50, 50, 50, 18); set_blk(50, 150, 300, 0, 0, 31);
    tick(); idle(); tick(); exp_combo++;
    checks++;
    if ({slice_valid, slice_saber, slice_id, slice_dir} !== {1'b1, 2'd1, 8'd31, 3'd0}) begin
      failures++; $display("FAIL window_edge_saber1 got=%0h exp=%0h", {slice_valid, slice_saber, slice_id, slice_dir}, {1'b1, 2'd1, 8'd31, 3'd0});
    end
    set_blk(50, 151, 300, 0, 0, 32);
    tick(); idle(); tick();
    checks++;
    if (slice_valid !== 1'b0) begin failures++; $display("FAIL window_outside got=%0b exp=0", slice_valid); end
    set_blk(50, 100, 300, 0, 2, 33);
    tick(); idle(); tick();
    checks++;
    if (slice_valid !== 1'b0) begin failures++; $display("FAIL wrong_dir got=%0b exp=0", slice_valid); end
  endtask

  task automatic test_cooldown();
    still_tips(); set_tip(0, 900, 900, 960, 900); set_blk(900, 900, 300, 0, 1, 50);
    tick();
    set_blk(900, 900, 300, 0, 1, 51); curr_time = curr_time - 18'd1;
    tick(); idle(); exp_combo++;
    checks++;
    if ({slice_valid, slice_id} !== {1'b1, 8'd50}) begin failures++; $display("FAIL cooldown_first got=%0h exp=%0h", {slice_valid, slice_id}, {1'b1, 8'd50}); end
    tick();
    checks++;
    if ({slice_valid, slice_id, combo} !== {1'b0, 8'd50, 8'(exp_combo)}) begin
      failures++; $display("FAIL cooldown_reject got=%0h exp=%0h", {slice_valid, slice_id, combo}, {1'b0, 8'd50, 8'(exp_combo)});
    end
    set_blk(900, 900, 300, 0, 1, 52);
    tick(); idle(); tick(); exp_combo++;
    checks++;
    if ({slice_valid, slice_id, combo} !== {1'b1, 8'd52, 8'(exp_combo)}) begin
      failures++; $display("FAIL cooldown_after got=%0h exp=%0h", {slice_valid, slice_id, combo}, {1'b1, 8'd52, 8'(exp_combo)});
    end
  endtask

  task automatic test_valid_low();
    still_tips(); set_tip(0, 900, 900, 960, 900); set_blk(900, 900, 0, 0, 1, 60); blk_valid = 0;
    tick(); tick();
    checks++;
    if ({slice_valid, miss_pulse, hit_pulse, slice_id, combo} !== {3'b000, 8'd52, 8'(exp_combo)}) begin
      failures++; $display("FAIL valid_low got=%0h exp=%0h", {slice_valid, miss_pulse, hit_pulse, slice_id, combo}, {3'b000, 8'd52, 8'(exp_combo)});
    end
    idle();
  endtask

  task automatic test_3d();
    logic e;
`ifdef SLICE_3D_EN
    e = 1'b0;
`else
    e = 1'b1;
`endif
    still_tips(); set_tip(0, 700, 700, 760, 700); set_blk(700, 700, 300, 0, 1, 70); tip_z[13:0] = 14'd0;
    tick(); idle(); tick();
    exp_combo += int'(e);
    checks++;
    if (slice_valid !== e) begin failures++; $display("FAIL depth_far got=%0b exp=%0b", slice_valid, e); end
    set_blk(700, 700, 300, 0, 1, 71); tip_z[13:0] = 14'd250;
    tick(); idle(); tick(); exp_combo++;
    checks++;
    if ({slice_valid, slice_id, combo} !== {1'b1, 8'd71, 8'(exp_combo)}) begin
      failures++; $display("FAIL depth_near got=%0h exp=%0h", {slice_valid, slice_id, combo}, {1'b1, 8'd71, 8'(exp_combo)});
    end
  endtask

  task automatic test_reset_mid();
    still_tips(); set_tip(0, 400, 400, 460, 400); set_blk(400, 400, 300, 0, 1, 80);
    tick(); idle();
    #2 rst_in_n = 0;
    #1;
    checks++;
    if ({slice_valid, combo} !== 9'd0) begin failures++; $display("FAIL reset_mid_async got=%0h exp=0", {slice_valid, combo}); end
    @(negedge clk_in) rst_in_n = 1;
    exp_combo = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (slice_valid !== 1'b0) begin failures++; $display("FAIL reset_mid_pulse cyc=%0d got=%0b exp=0", i, slice_valid); end
    end
  endtask

  function automatic int clip(input int v, input int hi);
    return v < 0 ? 0 : v > hi ? hi : v;
  endfunction

  function automatic int iabs(input int v);
    return v < 0 ? -v : v;
  endfunction

  task automatic test_random();
    int m_last_id = 255, m_last_time = 0, m_miss_id = 0, m_combo = 0;
    int bx = 0, by = 0, bz = 0, bdir = 0, bid = 0, hx = 0, hy = 0, hz = 0;
    logic vis = 0, obs = 0, col = 0, val;
    int px[NS], py[NS], cx[NS], cy[NS], tz[NS];
    logic [17:0] tt = 18'h3FFF0;
    exp_t held = '0, e, p = '0;
    idle();
    rst_in_n = 0;
    @(negedge clk_in) rst_in_n = 1;
    for (int n = 0; n < 1500; n++) begin
      if (n == 0 || $urandom_range(0, 9) >= 3) begin
        bx = $urandom_range(0, 4095); by = $urandom_range(0, 4095);
        bz = $urandom_range(0, 4) == 0 ? 0 : int'($urandom_range(0, 800));
        vis = $urandom_range(0, 9) != 0; obs = $urandom_range(0, 6) == 0; col = 1'($urandom_range(0, 1));
        bdir = $urandom_range(0, 4); bid = $urandom_range(0, 15);
        hx = clip(bx + int'($urandom_range(0, 260)) - 130, 4095); hy = clip(by + int'($urandom_range(0, 260)) - 130, 4095);
        hz = $urandom_range(0, 800);
      end
      val = $urandom_range(0, 7) != 0;
      for (int s = 0; s < NS; s++) begin
        int d, ax;
        px[s] = clip(bx + int'($urandom_range(0, 260)) - 130, 4095);
        py[s] = clip(by + int'($urandom_range(0, 260)) - 130, 4095);
        if ($urandom_range(0, 3) == 0) begin
          d = $urandom_range(0, 1) ? 31 + int'($urandom_range(0, 1)) : -31 - int'($urandom_range(0, 1));
          ax = $urandom_range(0, 1);
          cx[s] = clip(px[s] + (ax ? d : 0), 4095); cy[s] = clip(py[s] + (ax ? 0 : d), 4095);
        end else begin
          cx[s] = clip(px[s] + int'($urandom_range(0, 180)) - 90, 4095);
          cy[s] = clip(py[s] + int'($urandom_range(0, 180)) - 90, 4095);
        end
        tz[s] = clip(bz + int'($urandom_range(0, 260)) - 130, 16383);
      end
      begin
        bit found = 0, acc, miss, hit;
        int win = 0;
        for (int s = 0; s < NS; s++) begin
          int dx = cx[s] - px[s], dy = cy[s] - py[s], sd;
          bit ov;
          sd = (iabs(dx) >= 32 && iabs(dx) > iabs(dy)) ? (dx < 0 ? 3 : 1) : (iabs(dy) >= 32 && iabs(dy) > iabs(dx)) ? (dy < 0 ? 0 : 2) : 4;
          ov = px[s] - 100 <= bx && bx <= px[s] + 100 && py[s] - 100 <= by && by <= py[s] + 100;
`ifdef SLICE_3D_EN
          ov = ov && iabs(tz[s] - bz) <= 100;
`endif
          if (val && vis && !obs && bz <= 600 && sd != 4 && (sd == bdir || bdir == 4) && ov && !found) begin
            found = 1; win = s;
          end
        end
        acc = found && bid != m_last_id && ((int'(tt) - m_last_time) & 32'h3FFFF) >= 1;
        miss = val && vis && !obs && bz == 0 && bid != m_miss_id;
        hit = val && vis && obs && iabs(bx - hx) <= 100 && iabs(by - hy) <= 100 && bz <= hz;
        if (acc) begin
          held.saber = 2'(win); held.id = 8'(bid); held.x = 12'(bx); held.y = 12'(by); held.z = 14'(bz);
          held.color = col; held.dir = 3'(bdir);
          m_last_id = bid; m_last_time = int'(tt); m_combo = m_combo < 255 ? m_combo + 1 : 255;
        end
        if (miss) begin m_combo = 0; m_miss_id = bid; end
        e = held; e.sv = acc; e.miss = miss; e.hit = hit; e.combo = 8'(m_combo);
      end
      blk_valid = val; blk_visible = vis; blk_obstacle = obs; blk_color = col;
      blk_x = 12'(bx); blk_y = 12'(by); blk_z = 14'(bz); blk_dir = 3'(bdir); blk_id = 8'(bid);
      head_x = 12'(hx); head_y = 12'(hy); head_z = 14'(hz);
      for (int s = 0; s < NS; s++) begin
        set_tip(s, px[s], py[s], cx[s], cy[s]); tip_z[s*14 +: 14] = 14'(tz[s]);
      end
      curr_time = tt;
      tt = tt + 18'($urandom_range(0, 1));
      tick();
      if (n > 0) begin
        checks++;
        if ({slice_valid, miss_pulse, hit_pulse, combo} !== {p.sv, p.miss, p.hit, p.combo}) begin
          failures++; $display("FAIL rnd_pulses cyc=%0d got=%0h exp=%0h", n, {slice_valid, miss_pulse, hit_pulse, combo}, {p.sv, p.miss, p.hit, p.combo});
        end
        checks++;
        if ({slice_saber, slice_id, slice_x, slice_y, slice_z, slice_color, slice_dir} !== {p.saber, p.id, p.x, p.y, p.z, p.color, p.dir}) begin
          failures++; $display("FAIL rnd_slice_data cyc=%0d got=%0h exp=%0h", n, {slice_saber, slice_id, slice_x, slice_y, slice_z, slice_color, slice_dir}, {p.saber, p.id, p.x, p.y, p.z, p.color, p.dir});
        end
      end
      p = e;
    end
    idle(); tick();
    checks++;
    if ({slice_valid, miss_pulse, hit_pulse, combo} !== {p.sv, p.miss, p.hit, p.combo}) begin
      failures++; $display("FAIL rnd_last got=%0h exp=%0h", {slice_valid, miss_pulse, hit_pulse, combo}, {p.sv, p.miss, p.hit, p.combo});
    end
  endtask

  initial begin
    test_reset();
    test_slice();
    test_dual_sabers();
    test_threshold();
    test_miss();
    test_hit();
    test_window_edge();
    test_cooldown();
    test_valid_low();
    test_3d();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/slice_detector.md
SLICE_DETECTOR -- requirements
Module: slice_detector

Interface
REQ-001 The block SHALL have these parameters:
  NUM_SABERS, 2, number of tracked saber tips (1..4)
  MOVE_THRESHOLD, 32, minimum per-frame tip displacement, in pixels, that counts as a swing
  HIT_RADIUS, 100, half-width of the square overlap window, in pixels
  SLICE_Z_MAX, 600, largest block z at which a block can be sliced
  COOLDOWN, 1, curr_time ticks after a slice before any new slice is accepted
REQ-002 The block SHALL have these ports (clock and reset first):
  clk_in  in  1  single clock; all logic on rising edge
  rst_in_n  in  1  asynchronous active-low reset
  curr_time  in  18  game time tick
  blk_valid  in  1  block fields valid this cycle
  blk_x, blk_y  in  12 each  block centre
  blk_z  in  14  block depth
  blk_visible  in  1  block not yet broken
  blk_obstacle  in  1  block is an obstacle, not a note
  blk_color  in  1  block colour
  blk_dir  in  3  required cut direction: 0 UP, 1 RIGHT, 2 DOWN, 3 LEFT, 4 ANY
  blk_id  in  8  block identifier
  tip_prev_xy  in  NUM_SABERS*24  previous frame {x[11:0],y[11:0]} per saber; saber 0 in the LSBs
  tip_curr_xy  in  NUM_SABERS*24  current frame {x,y} per saber
  tip_z  in  NUM_SABERS*14  current tip depth per saber
  head_x, head_y  in  12 each  head position
  head_z  in  14  head depth
  slice_valid  out  1  one-cycle pulse: a slice was accepted
  slice_saber  out  2  index of the winning saber
  slice_id, slice_x, slice_y, slice_z, slice_color, slice_dir  out  8/12/12/14/1/3  registered copy of the sliced block
  miss_pulse  out  1  one-cycle pulse: a note reached z==0 unsliced
  hit_pulse  out  1  one-cycle pulse: an obstacle overlaps the head
  combo  out  8  count of consecutive slices, saturating at 255

Function
REQ-003 Stage 1 SHALL register, per saber: dx = curr_x - prev_x and dy = curr_y - prev_y, as 13-bit signed values, plus their absolute values, together with a copy of the block fields and blk_valid.
REQ-004 Direction SHALL be computed from the stage-1 values: RIGHT or LEFT if |dx| >= MOVE_THRESHOLD and |dx| > |dy| (sign of dx selects); otherwise DOWN or UP if |dy| >= MOVE_THRESHOLD and |dy| > |dx| (sign of dy selects); otherwise ANY. dx == 0 SHALL count as non-negative.
REQ-005 Overlap SHALL be true when prev_x - HIT_RADIUS <= blk_x <= prev_x + HIT_RADIUS, and the same test holds for y. The comparison SHALL use 14-bit signed arithmetic, so a window edge below 0 or above 4095 does not wrap.
REQ-006 A saber SHALL be a candidate when all of the following hold:
  - the block is valid, visible and not an obstacle;
  - blk_z <= SLICE_Z_MAX;
  - the saber direction is not ANY;
  - the saber direction equals blk_dir, or blk_dir is ANY;
  - the saber overlaps the block.
REQ-007 If several sabers are candidates in the same cycle, the lowest saber index SHALL win, and exactly one slice_valid pulse SHALL be produced.
REQ-008 A candidate SHALL be rejected if blk_id equals last_id, or if curr_time - last_time (18-bit modular arithmetic) < COOLDOWN.
REQ-009 An accepted slice SHALL do all of the following: assert slice_valid in stage 2 (two cycles after the inputs are sampled), load the slice_* outputs, set last_id = blk_id and last_time = curr_time, and increment combo.
REQ-010 The slice_* data outputs SHALL hold their values between slices.
REQ-011 miss_pulse SHALL pulse when a valid, visible, non-obstacle block has blk_z == 0 and blk_id differs from the last missed ID. A miss SHALL clear combo to 0.
REQ-012 If a slice and a miss occur in the same cycle, the slice increment SHALL apply first and the miss clear second, so combo ends at 0.
REQ-013 hit_pulse SHALL pulse for a valid, visible obstacle whose x/y lies within HIT_RADIUS of head_x/head_y and whose blk_z <= head_z. Its latency SHALL be two cycles.
REQ-014 When blk_valid is low, the block SHALL produce no pulses and SHALL leave all state unchanged.

Reset
REQ-015 Asserting rst_in_n low SHALL immediately clear:
  - all outputs;
  - the pipeline valid bits;
  - combo;
  - last_time;
  - the miss-ID register.
  last_id SHALL reset to 8'hFF.
REQ-016 A reset asserted mid-pipeline SHALL discard any in-flight slice, so no pulse follows the release of reset.

Configuration
REQ-017 With SLICE_3D_EN defined, overlap SHALL additionally require |tip_z - blk_z| <= HIT_RADIUS. Without it, tip_z SHALL be ignored and the test SHALL be 2D only.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
  - NUM_SABERS=2. Saber 0 moves prev (500,500) to curr (560,510); block (520,480), z=300, dir RIGHT, id 5 -> slice_valid two cycles later, slice_saber=0, combo=1.
  - Same block held on the next cycle -> no second pulse (same ID).
  - Both sabers swing DOWN over a block with dir ANY, id 9 -> a single pulse with slice_saber=0.
  - Saber moves by 31 pixels -> direction ANY, no slice; 32 pixels -> slice.
  - combo=3, then a note with z=0 and id 12 -> miss_pulse for one cycle, combo=0; the same id 12 next cycle -> no new miss pulse.
  - Obstacle at (100,100), z=50, with head at (150,120), z=60 -> hit_pulse after two cycles. With SLICE_3D_EN defined, tip_z=0 against blk_z=300 -> no slice.
